// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch interval meter.
package stopwatch_pkg;

  // Measurement state: waiting for arm, waiting for start, counting.
  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_ARMED = 2'd1,
    STATE_COUNT = 2'd2
  } state_t;

endpackage

// File: rtl/stopwatch.sv
// Interval meter: counts enabled clock cycles between a start and a stop
// event, with a programmable timeout and saturation at all-ones.
module stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clkena,
  input  logic             ctrl_arm,
  input  logic             ctrl_abort,
  input  logic [WIDTH-1:0] ctrl_limit,
  input  logic             evt_start,
  input  logic             evt_stop,
  output logic [WIDTH-1:0] stat_time,
  output logic             stat_armed,
  output logic             stat_busy,
  output logic             stat_done,
  output logic             stat_ovf
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // A zero limit means "no limit": the count then runs up to all-ones.
  function automatic logic [WIDTH-1:0] f_eff_limit(input logic [WIDTH-1:0] lim);
    return (lim == '0) ? ALL_ONES : lim;
  endfunction

  // Timeout when the next count reaches the limit, or when it would reach
  // all-ones (covers a limit lowered below the running count). This is
  // what keeps the counter from ever wrapping.
  function automatic logic f_timeout(input logic [WIDTH-1:0] nxt,
                                     input logic [WIDTH-1:0] lim);
    return (nxt == lim) || (nxt == ALL_ONES);
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_done;

  state_t           w_state_nx;
  logic [WIDTH-1:0] w_count_nx;
  logic             w_ovf_nx;
  logic             w_done_nx;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_limit;

  assign w_inc   = r_count + WIDTH'(1);
  assign w_limit = f_eff_limit(ctrl_limit);

  // Next-state logic; abort has top priority in every state, then stop,
  // then timeout.
  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_ovf_nx   = r_ovf;
    w_done_nx  = 1'b0;
    unique case (r_state)
      STATE_IDLE: begin
        if (ctrl_abort) begin
          w_state_nx = STATE_IDLE;
        end else if (ctrl_arm) begin
          w_state_nx = STATE_ARMED;
          w_count_nx = '0;
          w_ovf_nx   = 1'b0;
        end
      end
      STATE_ARMED: begin
        if (ctrl_abort) begin
          w_state_nx = STATE_IDLE;
        end else if (evt_start && evt_stop) begin
          w_state_nx = STATE_IDLE;
          w_count_nx = '0;
          w_done_nx  = 1'b1;
        end else if (evt_start) begin
          w_state_nx = STATE_COUNT;
          w_count_nx = '0;
        end
      end
      STATE_COUNT: begin
        if (ctrl_abort) begin
          w_state_nx = STATE_IDLE;
        end else if (evt_stop) begin
          w_state_nx = STATE_IDLE;
          w_count_nx = w_inc;
          w_done_nx  = 1'b1;
        end else if (f_timeout(w_inc, w_limit)) begin
          w_state_nx = STATE_IDLE;
          w_count_nx = w_inc;
          w_ovf_nx   = 1'b1;
          w_done_nx  = 1'b1;
        end else begin
          w_count_nx = w_inc;
        end
      end
      default: begin
        w_state_nx = STATE_IDLE;
      end
    endcase
  end

  // State registers: asynchronous clear, update only on enabled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= STATE_IDLE;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else if (clkena) begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_ovf   <= w_ovf_nx;
      r_done  <= w_done_nx;
    end
  end

  // The done pulse is masked in disabled cycles so it is only ever seen
  // together with clkena; the register itself holds like everything else.
  assign stat_time  = r_count;
  assign stat_armed = (r_state == STATE_ARMED);
  assign stat_busy  = (r_state == STATE_COUNT);
  assign stat_done  = r_done & clkena;
  assign stat_ovf   = r_ovf;

endmodule

// File: tb/tb_stopwatch.sv
// Self-checking bench for the stopwatch interval meter: directed scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_stopwatch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clkena = 1'b0;
  logic       ctrl_arm = 1'b0;
  logic       ctrl_abort = 1'b0;
  logic [7:0] ctrl_limit = 8'd0;
  logic       evt_start = 1'b0;
  logic       evt_stop = 1'b0;
  logic [7:0] stat_time;
  logic       stat_armed;
  logic       stat_busy;
  logic       stat_done;
  logic       stat_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: mode 0 idle, 1 waiting for start, 2 measuring.
  // Elapsed time is kept as an unbounded integer.
  int m_mode    = 0;
  int m_elapsed = 0;
  int m_time    = 0;
  bit m_ovf     = 1'b0;
  bit m_done    = 1'b0;

  stopwatch #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .clkena     (clkena),
    .ctrl_arm   (ctrl_arm),
    .ctrl_abort (ctrl_abort),
    .ctrl_limit (ctrl_limit),
    .evt_start  (evt_start),
    .evt_stop   (evt_stop),
    .stat_time  (stat_time),
    .stat_armed (stat_armed),
    .stat_busy  (stat_busy),
    .stat_done  (stat_done),
    .stat_ovf   (stat_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_elapsed = 0; m_time = 0; m_ovf = 1'b0; m_done = 1'b0;
  endtask

  // One enabled-cycle rule application, from the measurement rules.
  task automatic model_update(input bit a, input bit ab, input int lim,
                              input bit s, input bit p, input bit e);
    int limit_eff;
    int nxt;
    if (!e) return;
    m_done = 1'b0;
    limit_eff = (lim == 0) ? 255 : lim;
    if (m_mode == 0) begin
      if (!ab && a) begin
        m_mode = 1; m_time = 0; m_ovf = 1'b0;
      end
    end else if (m_mode == 1) begin
      if (ab) m_mode = 0;
      else if (s && p) begin
        m_mode = 0; m_time = 0; m_done = 1'b1;
      end else if (s) begin
        m_mode = 2; m_elapsed = 0; m_time = 0;
      end
    end else begin
      nxt = m_elapsed + 1;
      if (ab) m_mode = 0;
      else if (p) begin
        m_mode = 0; m_time = nxt; m_done = 1'b1;
      end else if (nxt == limit_eff || nxt >= 255) begin
        m_mode = 0; m_time = nxt; m_ovf = 1'b1; m_done = 1'b1;
      end else begin
        m_elapsed = nxt; m_time = nxt;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".time"},  stat_time,  m_time[7:0]);
    chk({tag, ".armed"}, stat_armed, (m_mode == 1));
    chk({tag, ".busy"},  stat_busy,  (m_mode == 2));
    chk({tag, ".done"},  stat_done,  m_done & clkena);
    chk({tag, ".ovf"},   stat_ovf,   m_ovf);
  endtask

  task automatic step(input string tag, input bit a, input bit ab, input logic [7:0] lim,
                      input bit s, input bit p, input bit e);
    ctrl_arm = a; ctrl_abort = ab; ctrl_limit = lim;
    evt_start = s; evt_stop = p; clkena = e;
    model_update(a, ab, int'(lim), s, p, e);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".time"},  stat_time,  0);
    chk({tag, ".armed"}, stat_armed, 0);
    chk({tag, ".busy"},  stat_busy,  0);
    chk({tag, ".done"},  stat_done,  0);
    chk({tag, ".ovf"},   stat_ovf,   0);
  endtask

  initial begin
    bit         r_arm, r_abort, r_start, r_stop, r_ena;
    logic [7:0] cur_lim;

    // Reset state
    clkena = 1'b1;
    #12;
    check_zero("por");
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();

    // 1: asynchronous reset while counting at 37
    step("t1arm", 1, 0, 8'd0, 0, 0, 1);
    step("t1start", 0, 0, 8'd0, 1, 0, 1);
    repeat (37) step("t1cnt", 0, 0, 8'd0, 0, 0, 1);
    chk("t1_count37", stat_time, 37);
    chk("t1_busy", stat_busy, 1);
    #3;
    reset = 1'b0;
    #1;
    check_zero("t1rst");
    model_reset();
    @(posedge clk);
    #2;
    check_zero("t1hold");
    reset = 1'b1;
    step("t1rearm", 1, 0, 8'd0, 0, 0, 1);
    chk("t1_armed", stat_armed, 1);

    // 2: start then stop five enabled cycles later, no limit
    repeat (3) step("t2wait", 0, 0, 8'd0, 0, 0, 1);
    step("t2start", 0, 0, 8'd0, 1, 0, 1);
    repeat (4) step("t2cnt", 0, 0, 8'd0, 0, 0, 1);
    step("t2stop", 0, 0, 8'd0, 0, 1, 1);
    chk("t2_time", stat_time, 5);
    chk("t2_done", stat_done, 1);
    chk("t2_ovf", stat_ovf, 0);
    chk("t2_busy", stat_busy, 0);
    step("t2after", 0, 0, 8'd0, 0, 0, 1);
    chk("t2_done_pulse", stat_done, 0);

    // 3: stop alone ignored while armed; simultaneous start+stop
    step("t3arm", 1, 0, 8'd0, 0, 0, 1);
    step("t3stoponly", 0, 0, 8'd0, 0, 1, 1);
    chk("t3_still_armed", stat_armed, 1);
    step("t3both", 0, 0, 8'd0, 1, 1, 1);
    chk("t3_done", stat_done, 1);
    chk("t3_time", stat_time, 0);

    // 4: timeout at limit 4, saturation with no limit, stop on timeout cycle
    step("t4arm", 1, 0, 8'd4, 0, 0, 1);
    step("t4start", 0, 0, 8'd4, 1, 0, 1);
    repeat (4) step("t4cnt", 0, 0, 8'd4, 0, 0, 1);
    chk("t4_time4", stat_time, 4);
    chk("t4_ovf4", stat_ovf, 1);
    chk("t4_done4", stat_done, 1);
    step("t4arm2", 1, 0, 8'd0, 0, 0, 1);
    chk("t4_ovf_cleared", stat_ovf, 0);
    step("t4start2", 0, 0, 8'd0, 1, 0, 1);
    repeat (255) step("t4sat", 0, 0, 8'd0, 0, 0, 1);
    chk("t4_time255", stat_time, 255);
    chk("t4_ovf255", stat_ovf, 1);
    chk("t4_done255", stat_done, 1);
    step("t4arm3", 1, 0, 8'd4, 0, 0, 1);
    step("t4start3", 0, 0, 8'd4, 1, 0, 1);
    repeat (3) step("t4cnt3", 0, 0, 8'd4, 0, 0, 1);
    step("t4stoplim", 0, 0, 8'd4, 0, 1, 1);
    chk("t4_stop_time", stat_time, 4);
    chk("t4_stop_ovf", stat_ovf, 0);

    // 5: alternating clock enable
    step("t5arm", 1, 0, 8'd0, 0, 0, 1);
    step("t5start", 0, 0, 8'd0, 1, 0, 1);
    step("t5a", 0, 0, 8'd0, 0, 0, 0);
    step("t5b", 0, 0, 8'd0, 0, 0, 1);
    step("t5c", 0, 0, 8'd0, 0, 1, 0);
    step("t5d", 0, 0, 8'd0, 0, 0, 1);
    step("t5e", 0, 0, 8'd0, 0, 0, 0);
    step("t5stop", 0, 0, 8'd0, 0, 1, 1);
    chk("t5_time", stat_time, 3);
    chk("t5_done", stat_done, 1);
    step("t5off", 0, 0, 8'd0, 0, 0, 0);
    chk("t5_done_masked", stat_done, 0);

    // 6: abort, abort beating stop, arm+abort in idle, re-arm clears
    step("t6arm", 1, 0, 8'd0, 0, 0, 1);
    step("t6start", 0, 0, 8'd0, 1, 0, 1);
    repeat (9) step("t6cnt", 0, 0, 8'd0, 0, 0, 1);
    step("t6abort", 0, 1, 8'd0, 0, 0, 1);
    chk("t6_busy", stat_busy, 0);
    chk("t6_nodone", stat_done, 0);
    chk("t6_time", stat_time, 9);
    step("t6armabort", 1, 1, 8'd0, 0, 0, 1);
    chk("t6_stay_idle", stat_armed, 0);
    chk("t6_keep_time", stat_time, 9);
    step("t6arm2", 1, 0, 8'd1, 0, 0, 1);
    step("t6start2", 0, 0, 8'd1, 1, 0, 1);
    step("t6to", 0, 0, 8'd1, 0, 0, 1);
    chk("t6_to_ovf", stat_ovf, 1);
    step("t6arm3", 1, 0, 8'd0, 0, 0, 1);
    step("t6start3", 0, 0, 8'd0, 1, 0, 1);
    repeat (2) step("t6cnt3", 0, 0, 8'd0, 0, 0, 1);
    step("t6stopabort", 0, 1, 8'd0, 0, 1, 1);
    chk("t6_sa_nodone", stat_done, 0);
    chk("t6_sa_time", stat_time, 2);
    step("t6rearm", 1, 0, 8'd0, 0, 0, 1);
    chk("t6_rearm_time", stat_time, 0);
    chk("t6_rearm_ovf", stat_ovf, 0);

    // Randomized traffic, including limit changes mid-count
    cur_lim = 8'd6;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        case ($urandom_range(0, 3))
          0: cur_lim = 8'd0;
          1: cur_lim = 8'($urandom_range(1, 4));
          2: cur_lim = 8'($urandom_range(1, 30));
          default: cur_lim = 8'($urandom);
        endcase
      end
      r_arm   = ($urandom_range(0, 99) < 30);
      r_abort = ($urandom_range(0, 99) < 2);
      r_start = ($urandom_range(0, 99) < 25);
      r_stop  = ($urandom_range(0, 99) < 6);
      r_ena   = ($urandom_range(0, 99) < 80);
      step("rnd", r_arm, r_abort, cur_lim, r_start, r_stop, r_ena);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
